// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the core and the data memory.
// master = core side, slave = memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_load, req_store, req_addr, req_size, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_load, req_store, req_addr, req_size, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: byte-lane RAM access after a
// fixed latency, result returned through a valid/ready response.
module data_mem_responder #(
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  reset,
    data_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] off_q, off_d;
    logic [2:0]    size_q, size_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          load_q, load_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rerr_q, rerr_d;
    logic          wr_en;

    logic [7:0]    mem_q [DEPTH_BYTES];

    logic          size_ok;
    logic          misalign;
    logic          below;
    logic [32:0]   end_w;
    logic          req_err;
    logic [AW-1:0] off_w;
    logic [31:0]   rd_word;

    // Request legality is judged on the raw inputs at the acceptance edge.
    always_comb begin
        size_ok  = (bus.req_size == 3'd1) || (bus.req_size == 3'd2) ||
                   (bus.req_size == 3'd4);
        misalign = ((bus.req_size == 3'd2) && bus.req_addr[0]) ||
                   ((bus.req_size == 3'd4) && (|bus.req_addr[1:0]));
        below    = bus.req_addr < ADDR_BASE;
        end_w    = {1'b0, bus.req_addr} - {1'b0, ADDR_BASE} +
                   {30'b0, bus.req_size};
        req_err  = (bus.req_load == bus.req_store) || !size_ok || misalign ||
                   below || (end_w > 33'(DEPTH_BYTES));
        off_w    = bus.req_addr[AW-1:0] - ADDR_BASE[AW-1:0];
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < size_q) begin
                rd_word[8*k +: 8] = mem_q[off_q + AW'(k)];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    off_d   = off_w;
                    size_d  = bus.req_size;
                    wdata_d = bus.req_wdata;
                    load_d  = bus.req_load;
                    err_d   = req_err;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    wr_en   = !err_q && !load_q;
                    rerr_d  = err_q;
                    rdata_d = (err_q || !load_q) ? 32'h0 : rd_word;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rdata_d = '0;
                    rerr_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    // RAM has no reset; a reset edge suppresses a pending commit.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < size_q) begin
                    mem_q[off_q + AW'(k)] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rerr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 main instance plus a
// LATENCY=1 instance sharing the request fields.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        v;
    logic        ld, st;
    logic [31:0] addr, wdata;
    logic [2:0]  size;
    logic        rr;
    int          nchk = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    data_mem_responder_if if0 ();
    data_mem_responder_if if1 ();

    assign if0.req_valid = v & !sel;
    assign if1.req_valid = v & sel;
    assign if0.req_load  = ld;
    assign if1.req_load  = ld;
    assign if0.req_store = st;
    assign if1.req_store = st;
    assign if0.req_addr  = addr;
    assign if1.req_addr  = addr;
    assign if0.req_size  = size;
    assign if1.req_size  = size;
    assign if0.req_wdata = wdata;
    assign if1.req_wdata = wdata;
    assign if0.rsp_ready = rr;
    assign if1.rsp_ready = rr;

    data_mem_responder #(.DEPTH_BYTES(4096), .LATENCY(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    data_mem_responder #(.DEPTH_BYTES(4096), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;

    assign m_req_ready = sel ? if1.req_ready : if0.req_ready;
    assign m_rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
    assign m_rsp_err   = sel ? if1.rsp_err   : if0.rsp_err;
    assign m_rsp_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic l, input logic s,
                          input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input logic [31:0] exp_d,
                          input logic exp_e, input int exp_lat);
        int n;
        @(negedge clk);
        ld = l; st = s; addr = a; size = sz; wdata = wd; v = 1'b1;
        n = 0;
        while (!m_req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".rdy"}, 32'(m_req_ready), 32'd1);
        @(posedge clk);
        #1;
        v = 1'b0;
        n = 0;
        while (!m_rsp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
        chk({tag, ".data"}, m_rsp_rdata, exp_d);
        chk({tag, ".err"}, 32'(m_rsp_err), 32'(exp_e));
        @(posedge clk);
        #1;
        chk({tag, ".done"}, {30'b0, m_rsp_valid, m_req_ready}, 32'b01);
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; v = 1'b0; ld = 1'b0; st = 1'b0;
        addr = '0; wdata = '0; size = 3'd4; rr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(if0.req_ready), 32'd0);
        chk("rst.valid", 32'(if0.rsp_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle.ready", 32'(if0.req_ready), 32'd1);
        chk("idle.rsp", {if0.rsp_rdata[30:0], if0.rsp_err}, 32'd0);

        do_req("st_w", 0, 1, 32'h10, 4, 32'hDEADBEEF, 32'h0, 0, 2);
        do_req("ld_w", 1, 0, 32'h10, 4, 32'h0, 32'hDEADBEEF, 0, 2);

        do_req("st_w20", 0, 1, 32'h20, 4, 32'h11223344, 32'h0, 0, 2);
        do_req("st_b21", 0, 1, 32'h21, 1, 32'hFFFFFFAA, 32'h0, 0, 2);
        do_req("ld_w20", 1, 0, 32'h20, 4, 32'h0, 32'h1122AA44, 0, 2);
        do_req("ld_h22", 1, 0, 32'h22, 2, 32'h0, 32'h00001122, 0, 2);
        do_req("ld_b23", 1, 0, 32'h23, 1, 32'h0, 32'h00000011, 0, 2);

        do_req("e_mis", 1, 0, 32'h21, 2, 32'h0, 32'h0, 1, 2);
        do_req("e_sz3", 0, 1, 32'h30, 3, 32'h12345678, 32'h0, 1, 2);
        do_req("st_top", 0, 1, 32'd4092, 4, 32'h01020304, 32'h0, 0, 2);
        do_req("e_oob", 0, 1, 32'd4094, 4, 32'hFFFFFFFF, 32'h0, 1, 2);
        do_req("e_oob2", 1, 0, 32'd4096, 4, 32'h0, 32'h0, 1, 2);
        do_req("ld_top", 1, 0, 32'd4092, 4, 32'h0, 32'h01020304, 0, 2);
        do_req("e_both", 1, 1, 32'h10, 4, 32'h0, 32'h0, 1, 2);
        do_req("e_none", 0, 0, 32'h10, 4, 32'h0, 32'h0, 1, 2);
        do_req("ld_w10b", 1, 0, 32'h10, 4, 32'h0, 32'hDEADBEEF, 0, 2);

        // backpressure: response held, a new request is ignored
        @(negedge clk);
        rr = 1'b0;
        ld = 1'b1; st = 1'b0; addr = 32'h20; size = 3'd4; v = 1'b1;
        @(posedge clk);
        #1;
        ld = 1'b0; st = 1'b1; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", 32'(if0.rsp_valid), 32'd1);
            chk("bp.data", if0.rsp_rdata, 32'h1122AA44);
            chk("bp.err", 32'(if0.rsp_err), 32'd0);
            chk("bp.ready", 32'(if0.req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rr = 1'b1; v = 1'b0;
        @(posedge clk);
        #1;
        chk("bp.rel", {30'b0, if0.rsp_valid, if0.req_ready}, 32'b01);
        do_req("bp.chk", 1, 0, 32'h20, 4, 32'h0, 32'h1122AA44, 0, 2);

        // reset one cycle after accepting a store
        do_req("st_40z", 0, 1, 32'h40, 4, 32'h0, 32'h0, 0, 2);
        @(negedge clk);
        ld = 1'b0; st = 1'b1; addr = 32'h40; size = 3'd4;
        wdata = 32'hCAFEF00D; v = 1'b1;
        @(posedge clk);
        #1;
        v = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rm.valid", 32'(if0.rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rm.idle", {30'b0, if0.rsp_valid, if0.req_ready}, 32'b01);
        end
        do_req("rm.ld", 1, 0, 32'h40, 4, 32'h0, 32'h00000000, 0, 2);

        // LATENCY=1 instance, requests issued as soon as ready returns
        sel = 1'b1;
        do_req("l1.st", 0, 1, 32'h8, 4, 32'h12345678, 32'h0, 0, 1);
        do_req("l1.ld", 1, 0, 32'h8, 4, 32'h0, 32'h12345678, 0, 1);
        do_req("l1.sth", 0, 1, 32'hA, 2, 32'h0000BEEF, 32'h0, 0, 1);
        do_req("l1.ldw", 1, 0, 32'h8, 4, 32'h0, 32'hBEEF5678, 0, 1);
        do_req("l1.ldb", 1, 0, 32'h9, 1, 32'h0, 32'h00000056, 0, 1);
        do_req("l1.err", 1, 0, 32'hA, 4, 32'h0, 32'h0, 1, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
